x25519_mult_driver: RTL and testbench

Initiator and consumer for the X25519 multiply-pass unit. On start it issues the 32 column passes (i = 0..31) to the pass unit and collects each 32-bit column sum. It then runs two carry-squeeze passes, matching the radix-2^8 reference arithmetic, and presents the partially reduced 264-bit product. It sits between the field-arithmetic sequencer (upstream) and one multiply-pass instance (downstream).

---
 rtl/x25519_mult_driver.sv | 191 +++++++++++++++++++
 tb/tb_x25519_mult_driver.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x25519_mult_driver.sv
// Drives 32 column passes through one X25519 multiply-pass unit, then runs two carry
// squeezes to give a partially reduced 264-bit product. Option: X25519_MULT_OVERLAP_EN.
module x25519_mult_driver #(
  parameter int unsigned WORDS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [263:0] a,
  input  logic [263:0] b,
  output logic         busy,
  output logic         done,
  output logic [263:0] result,
  output logic         pass_en,
  output logic [263:0] pass_a,
  output logic [263:0] pass_b,
  output logic [4:0]   pass_i,
  input  logic         pass_valid,
  input  logic [31:0]  pass_out
);

  localparam logic [4:0] LastIdx = 5'(WORDS - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StSq1, StSq2, StDone} state_e;

  state_e                       state_q, state_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic [263:0]                 result_q, result_d;
  logic                         pass_en_q, pass_en_d;
  logic [263:0]                 pass_a_q, pass_a_d;
  logic [263:0]                 pass_b_q, pass_b_d;
  logic [4:0]                   pass_i_q, pass_i_d;
  logic [4:0]                   j_q, j_d;
  logic [32:0]                  u_q, u_d;
  logic [WORDS-1:0][15:0]       limb_q, limb_d;
`ifndef X25519_MULT_OVERLAP_EN
  logic [WORDS-1:0][31:0]       col_q, col_d;
`endif
  logic [32:0]                  sum;
  logic [263:0]                 limbs_flat;

  // Limbs 0..30 contribute their low byte; limb 31 keeps its full 16 bits.
  always_comb begin
    limbs_flat = '0;
    for (int k = 0; k < int'(WORDS) - 1; k++) begin
      limbs_flat[8*k +: 8] = limb_q[k][7:0];
    end
    limbs_flat[263:248] = limb_q[WORDS-1];
  end

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    pass_en_d = 1'b0;
    pass_a_d  = pass_a_q;
    pass_b_d  = pass_b_q;
    pass_i_d  = pass_i_q;
    j_d       = j_q;
    u_d       = u_q;
    limb_d    = limb_q;
`ifndef X25519_MULT_OVERLAP_EN
    col_d     = col_q;
`endif
    sum       = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          pass_a_d = a;
          pass_b_d = b;
          pass_i_d = '0;
          j_d      = '0;
          u_d      = '0;
          busy_d   = 1'b1;
          result_d = '0;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        pass_en_d = 1'b1;
        state_d   = StWait;
      end
      StWait: begin
        if (pass_valid) begin
`ifdef X25519_MULT_OVERLAP_EN
          // First squeeze folded in: each column is carried into u as it arrives.
          sum = u_q + {1'b0, pass_out};
          if (pass_i_q == LastIdx) begin
            limb_d[WORDS-1] = {9'b0, sum[6:0]};
            u_d             = (sum >> 7) * 33'd19;
            j_d             = '0;
            state_d         = StSq2;
          end else begin
            limb_d[pass_i_q] = {8'b0, sum[7:0]};
            u_d              = sum >> 8;
            pass_i_d         = pass_i_q + 5'd1;
            state_d          = StIssue;
          end
`else
          col_d[pass_i_q] = pass_out;
          if (pass_i_q == LastIdx) begin
            state_d = StSq1;
          end else begin
            pass_i_d = pass_i_q + 5'd1;
            state_d  = StIssue;
          end
`endif
        end
      end
`ifndef X25519_MULT_OVERLAP_EN
      StSq1: begin
        sum = u_q + {1'b0, col_q[j_q]};
        if (j_q == LastIdx) begin
          // Bits above 2^255 wrap back in as 19x since 2^255 = 19 mod p.
          limb_d[WORDS-1] = {9'b0, sum[6:0]};
          u_d             = (sum >> 7) * 33'd19;
          j_d             = '0;
          state_d         = StSq2;
        end else begin
          limb_d[j_q] = {8'b0, sum[7:0]};
          u_d         = sum >> 8;
          j_d         = j_q + 5'd1;
        end
      end
`endif
      StSq2: begin
        if (j_q == LastIdx) begin
          limb_d[WORDS-1] = u_q[15:0] + limb_q[WORDS-1];
          state_d         = StDone;
        end else begin
          sum         = u_q + {25'b0, limb_q[j_q][7:0]};
          limb_d[j_q] = {8'b0, sum[7:0]};
          u_d         = sum >> 8;
          j_d         = j_q + 5'd1;
        end
      end
      StDone: begin
        result_d = limbs_flat;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      pass_en_q <= 1'b0;
      pass_a_q  <= '0;
      pass_b_q  <= '0;
      pass_i_q  <= '0;
      j_q       <= '0;
      u_q       <= '0;
      limb_q    <= '0;
`ifndef X25519_MULT_OVERLAP_EN
      col_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      pass_en_q <= pass_en_d;
      pass_a_q  <= pass_a_d;
      pass_b_q  <= pass_b_d;
      pass_i_q  <= pass_i_d;
      j_q       <= j_d;
      u_q       <= u_d;
      limb_q    <= limb_d;
`ifndef X25519_MULT_OVERLAP_EN
      col_q     <= col_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign pass_en = pass_en_q;
  assign pass_a  = pass_a_q;
  assign pass_b  = pass_b_q;
  assign pass_i  = pass_i_q;

endmodule

// File: tb/tb_x25519_mult_driver.sv
// Bench for x25519_mult_driver: behavioural pass unit with fixed latency, result scoreboard.
module tb_x25519_mult_driver;

  localparam int PassLat = 3;
`ifdef X25519_MULT_OVERLAP_EN
  localparam int ExpLat = 32 * (2 + PassLat) + 33;
`else
  localparam int ExpLat = 32 * (2 + PassLat) + 65;
`endif
  localparam logic [527:0] PMod = (528'd1 << 255) - 528'd19;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [263:0] a = '0;
  logic [263:0] b = '0;
  logic         busy, done, pass_en;
  logic [263:0] result, pass_a, pass_b;
  logic [4:0]   pass_i;
  logic         pass_valid;
  logic [31:0]  pass_out;
  logic         pv_m = 1'b0;
  logic         pv_sp = 1'b0;
  logic [31:0]  po_m = '0;

  assign pass_valid = pv_m | pv_sp;
  assign pass_out   = pv_sp ? 32'hDEADBEEF : po_m;

  x25519_mult_driver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .pass_en   (pass_en),
    .pass_a    (pass_a),
    .pass_b    (pass_b),
    .pass_i    (pass_i),
    .pass_valid(pass_valid),
    .pass_out  (pass_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [263:0] v;
    bit           modp;
  } exp_t;
  exp_t sb_q[$];

  int           en_cnt = 0;
  int           exp_idx = 0;
  logic [263:0] cur_a = '0;
  logic [263:0] cur_b = '0;

  // Column i of a*b with columns above 31 folded back as 38x (2^256 = 38 mod p).
  function automatic logic [31:0] colsum(logic [263:0] x, logic [263:0] y, int i);
    logic [31:0] s, xa, yb;
    s = '0;
    for (int j = 0; j < 32; j++) begin
      xa = 32'(x[8*j +: 8]);
      if (j <= i) yb = 32'(y[8*(i-j) +: 8]);
      else        yb = 32'd38 * 32'(y[8*(i+32-j) +: 8]);
      s = s + xa * yb;
    end
    return s;
  endfunction

  // Behavioural pass unit: answers PassLat cycles after seeing pass_en.
  int          rem = 0;
  logic [31:0] colv = '0;
  always @(negedge clk) begin
    pv_m = 1'b0;
    if (rem > 0) begin
      rem = rem - 1;
      if (rem == 0) begin
        pv_m = 1'b1;
        po_m = colv;
      end
    end
    if (pass_en === 1'b1) begin
      vectors++;
      if (pass_i !== 5'(exp_idx)) begin
        miscompares++;
        $display("FAIL pass_order: pass_i=%0d required %0d", pass_i, exp_idx);
      end
      vectors++;
      if (pass_a !== cur_a || pass_b !== cur_b) begin
        miscompares++;
        $display("FAIL pass_operands: pass_a=%h pass_b=%h required %h %h",
                 pass_a, pass_b, cur_a, cur_b);
      end
      exp_idx++;
      en_cnt++;
      rem  = PassLat;
      colv = colsum(pass_a, pass_b, int'(pass_i));
    end
  end

  exp_t         mon_e;
  logic [263:0] mon_got;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL done_extra: done pulse with result=%h but none expected", result);
      end else begin
        mon_e   = sb_q.pop_front();
        mon_got = mon_e.modp ? 264'((528'(result)) % PMod) : result;
        if (mon_got !== mon_e.v) begin
          miscompares++;
          $display("FAIL result: got %h required %h (modp=%0d)", mon_got, mon_e.v, mon_e.modp);
        end
      end
    end
  end

  task automatic run_op(input logic [263:0] x, input logic [263:0] y, input logic [263:0] ev,
                        input bit modp, input bit rerequest, output int lat);
    exp_t e;
    int   n;
    @(negedge clk);
    cur_a   = x;
    cur_b   = y;
    exp_idx = 0;
    en_cnt  = 0;
    a       = x;
    b       = y;
    start   = 1'b1;
    e.v     = ev;
    e.modp  = modp;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a     = '1;
    b     = '1;
    vectors++;
    if (busy !== 1'b1 || result !== '0) begin
      miscompares++;
      $display("FAIL start_accept: busy=%b result=%h required busy=1 result=0", busy, result);
    end
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
      start = (rerequest && n == 50);
    end
    start = 1'b0;
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_timeout: done=%b after %0d cycles required 1", done, n);
    end
    lat = n;
    vectors++;
    if (en_cnt != 32) begin
      miscompares++;
      $display("FAIL pass_count: %0d pass_en pulses required 32", en_cnt);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || (!modp && result !== ev)) begin
      miscompares++;
      $display("FAIL after_done: done=%b busy=%b result=%h required 0 0 %h",
               done, busy, result, ev);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || pass_en !== 1'b0 ||
        pass_a !== '0 || pass_b !== '0 || pass_i !== '0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b result=%h pass_en=%b pass_i=%0d required all 0",
               busy, done, result, pass_en, pass_i);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    run_op(264'd2, 264'd3, 264'd6, 1'b0, 1'b0, lat);
    vectors++;
    if (lat != ExpLat) begin
      miscompares++;
      $display("FAIL latency: %0d cycles required %0d", lat, ExpLat);
    end
  endtask

  task automatic test_prime();
    logic [263:0] pv;
    int lat;
    pv = '0;
    for (int k = 0; k < 31; k++) pv[8*k +: 8] = (k == 0) ? 8'hED : 8'hFF;
    pv[263:248] = 16'h007F;
    run_op(pv, 264'd1, pv, 1'b0, 1'b0, lat);
  endtask

  task automatic test_wrap();
    int lat;
    run_op(264'h80 << 248, 264'd1, 264'h13, 1'b0, 1'b0, lat);
  endtask

  task automatic test_fold38();
    int lat;
    run_op(264'd1 << 128, 264'd1 << 128, 264'h26, 1'b0, 1'b0, lat);
  endtask

  task automatic test_random();
    logic [263:0] x, y;
    logic [527:0] prod;
    int lat;
    for (int t = 0; t < 2; t++) begin
      x = '0;
      y = '0;
      for (int k = 0; k < 8; k++) begin
        x[32*k +: 32] = $urandom;
        y[32*k +: 32] = $urandom;
      end
      prod = (528'(x[255:0]) * 528'(y[255:0])) % PMod;
      run_op(x, y, 264'(prod), 1'b1, 1'b0, lat);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    cur_a   = 264'd5;
    cur_b   = 264'd7;
    exp_idx = 0;
    en_cnt  = 0;
    a       = 264'd5;
    b       = 264'd7;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(pass_en === 1'b1 && pass_i === 5'd10) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (pass_i !== 5'd10) begin
      miscompares++;
      $display("FAIL reset_mid_reach: pass_i=%0d required 10", pass_i);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || pass_en !== 1'b0 || pass_i !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h pass_en=%b pass_i=%0d required all 0",
               busy, done, result, pass_en, pass_i);
    end
    repeat (6) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || pass_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_idle: busy=%b pass_en=%b required 0 0", busy, pass_en);
    end
    test_basic();
  endtask

  task automatic test_busy_start_spurious();
    int lat;
    bit bad;
    run_op(264'd7, 264'd9, 264'd63, 1'b0, 1'b1, lat);
    vectors++;
    if (lat != ExpLat) begin
      miscompares++;
      $display("FAIL busy_start_latency: %0d cycles required %0d", lat, ExpLat);
    end
    en_cnt = 0;
    bad    = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pv_sp = 1'b1;
      @(negedge clk);
      if (pass_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    pv_sp = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bad || en_cnt != 0 || result !== 264'd63) begin
      miscompares++;
      $display("FAIL spurious_valid: bad=%b pass_en_count=%0d result=%h required 0 0 %h",
               bad, en_cnt, result, 264'd63);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prime();
    test_wrap();
    test_fold38();
    test_random();
    test_reset_mid();
    test_busy_start_spurious();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d results pending required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
